spi_flash_ctrl: RTL and testbench
=================================

SPI_FLASH_CTRL -- requirements
Module: spi_flash_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SCK half-period in clk cycles; legal range 1..255.
REQ-002 SHALL have parameter ADDR_DATA, default 16'h0040: IO address of the data register.
REQ-003 SHALL have parameter ADDR_CTRL, default 16'h0041: IO address of the control/status register.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port io_wr, input, 1: CPU IO write strobe.
REQ-007 SHALL have port io_rd, input, 1: CPU IO read strobe.
REQ-008 SHALL have port mem_addr, input, 16: IO address.
REQ-009 SHALL have port dout, input, 16: CPU write data.
REQ-010 SHALL have port io_din, output, 16: read data; ORed into the top-level read bus.
REQ-011 SHALL have ports pio_sck, pio_si and pio_ssb, input, 1 each: bit-bang pin values from the PIOS register.
REQ-012 SHALL have ports spi_clk, spi_si and spi_ssb, output, 1 each: flash SCK, SDI and CS#.
REQ-013 SHALL have port spi_so, input, 1: flash SDO.
REQ-014 SHALL have port busy, output, 1: a byte transfer is in progress.

Function
REQ-015 SHALL keep two control bits:
- own: 1 = engine drives the flash pins; 0 = pio_* pass straight through to spi_*.
- cs: 1 = chip selected.
REQ-016 SHALL update own and cs from dout[0] and dout[1] on io_wr to ADDR_CTRL.
REQ-017 SHALL drive the pins combinationally from the current state:
- own=1: spi_ssb = ~cs; spi_clk = engine SCK; spi_si = engine SI.
- own=0: spi_clk = pio_sck; spi_si = pio_si; spi_ssb = pio_ssb.
REQ-018 SHALL implement an SPI mode-0 byte engine: SCK idles low; MSB first; SI changes only while SCK is low; SO is sampled in the clk cycle in which SCK rises.
REQ-019 SHALL use the states IDLE, LOW and HIGH.
REQ-020 SHALL start a transfer on io_wr to ADDR_DATA when state is IDLE and own=1:
- load the shift register with dout[7:0];
- set SI = dout[7], bit count = 0, half-period counter = CLK_DIV-1;
- go to LOW.
REQ-021 In LOW, SHALL decrement the counter; at 0, raise SCK, shift spi_so into the LSB of rx, reload the counter, and go to HIGH.
REQ-022 In HIGH, SHALL decrement the counter; at 0:
- lower SCK;
- if bit count = 7, go to IDLE;
- otherwise shift tx left, present the next bit on SI, increment the bit count, reload the counter, and go to LOW.
REQ-023 SHALL assert busy in every cycle in which state is not IDLE; busy rises the cycle after the accepted write and stays high for exactly 16*CLK_DIV cycles.
REQ-024 SHALL ignore a data write while busy and set the sticky flag ovr; a data write while own=0 is ignored without setting ovr.
REQ-025 SHALL clear ovr on io_wr to ADDR_CTRL with dout[15]=1; if a set and a clear occur in the same cycle, the set wins.
REQ-026 SHALL abort any transfer when own is written to 0: next state IDLE, SCK low, rx holds the partial byte.
REQ-027 SHALL not abort a transfer on a cs change; the change takes effect on spi_ssb immediately.
REQ-028 SHALL return io_din = {8'd0, rx} for ADDR_DATA.
REQ-029 SHALL return io_din = {12'd0, ovr, busy, cs, own} for ADDR_CTRL.
REQ-030 SHALL return io_din = 16'd0 for any other address.
REQ-031 SHALL derive io_din combinationally from mem_addr alone; io_rd has no side effects.
REQ-032 SHALL let the bit count wrap only via the return to IDLE, never through 8.
REQ-033 At CLK_DIV=1, SHALL toggle SCK every clk cycle and take 16 cycles per byte.

Reset
REQ-034 On reset=1 at a clk edge, SHALL set state IDLE, own=0, cs=0, ovr=0, SCK=0, SI=0, rx=8'h00, tx=8'h00, counters 0 and busy=0, overriding any concurrent IO write.
REQ-035 While reset is asserted, and in the cycle after, spi_* SHALL follow pio_* (own=0); reset in mid-transfer SHALL leave no SCK edge pending.

Verification
REQ-036 Scenario, byte transfer: CLK_DIV=2; write ctrl 16'h0003; write data 16'h00A5 with spi_so looped to spi_si -> 8 SCK pulses, SI = 1,0,1,0,0,1,0,1; busy high for 32 cycles; data read = 16'h00A5; spi_ssb = 0 throughout.
REQ-037 Scenario, pass-through: own=0; toggle pio_sck/pio_si/pio_ssb -> spi_* mirror them in the same cycle; data write -> busy stays 0 and ovr stays 0.
REQ-038 Scenario, overrun: write data 16'h0012 then 16'h0034 within 5 cycles -> second write ignored, ctrl read = 16'h000F; write ctrl 16'h8003 -> ctrl read = 16'h0003 once idle.
REQ-039 Scenario, abort: during bit 3, write ctrl 16'h0000 -> next cycle busy = 0, SCK = 0, pins follow pio_*; a new transfer after own=1 completes normally.
REQ-040 Scenario, reset mid-transfer: reset for 1 cycle at bit 5 -> all outputs and registers at REQ-034 values; ctrl read = 16'h0000.
REQ-041 Scenario, minimum divider: CLK_DIV=1, tx 8'hFF with spi_so = 0 -> 16-cycle busy; rx = 8'h00; SCK period = 2 clk cycles.

Source files
------------

// File: rtl/spi_flash_ctrl.sv
// IO-mapped SPI flash controller: mode-0 byte engine with a bit-bang pass-through path.
// The CPU owns the pins through PIOS until it sets "own", then the engine drives them.
module spi_flash_ctrl #(
    parameter int unsigned CLK_DIV   = 2,
    parameter logic [15:0] ADDR_DATA = 16'h0040,
    parameter logic [15:0] ADDR_CTRL = 16'h0041
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [15:0] mem_addr,
    input  logic [15:0] dout,
    output logic [15:0] io_din,
    input  logic        pio_sck,
    input  logic        pio_si,
    input  logic        pio_ssb,
    output logic        spi_clk,
    output logic        spi_si,
    output logic        spi_ssb,
    input  logic        spi_so,
    output logic        busy
);

    localparam logic [7:0] DivReload = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StHigh
    } state_e;

    state_e      state_q;
    logic        own_q;
    logic        cs_q;
    logic        ovr_q;
    logic        sck_q;
    logic        si_q;
    logic [7:0]  rx_q;
    logic [7:0]  tx_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  cnt_q;

    logic        wr_data;
    logic        wr_ctrl;
    logic        unused_bits;

    assign wr_data = io_wr && (mem_addr == ADDR_DATA);
    assign wr_ctrl = io_wr && (mem_addr == ADDR_CTRL);

    // Reads are side-effect free, so the strobe and the unassigned ctrl bits are don't-cares.
    assign unused_bits = ^{io_rd, dout[14:8]};

    assign busy = (state_q != StIdle);

    always_comb begin
        if (own_q) begin
            spi_clk = sck_q;
            spi_si  = si_q;
            spi_ssb = ~cs_q;
        end else begin
            spi_clk = pio_sck;
            spi_si  = pio_si;
            spi_ssb = pio_ssb;
        end
    end

    always_comb begin
        io_din = 16'd0;
        if (mem_addr == ADDR_DATA) begin
            io_din = {8'd0, rx_q};
        end else if (mem_addr == ADDR_CTRL) begin
            io_din = {12'd0, ovr_q, busy, cs_q, own_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            own_q     <= 1'b0;
            cs_q      <= 1'b0;
            ovr_q     <= 1'b0;
            sck_q     <= 1'b0;
            si_q      <= 1'b0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
            bit_cnt_q <= 3'd0;
            cnt_q     <= 8'd0;
        end else begin
            // Overrun set has priority over the software clear.
            if (wr_data && (state_q != StIdle)) begin
                ovr_q <= 1'b1;
            end else if (wr_ctrl && dout[15]) begin
                ovr_q <= 1'b0;
            end

            if (wr_ctrl) begin
                own_q <= dout[0];
                cs_q  <= dout[1];
            end

            if (wr_ctrl && !dout[0]) begin
                // Releasing the pins aborts; rx keeps whatever was shifted in so far.
                state_q <= StIdle;
                sck_q   <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (wr_data && own_q) begin
                            tx_q      <= dout[7:0];
                            si_q      <= dout[7];
                            bit_cnt_q <= 3'd0;
                            cnt_q     <= DivReload;
                            state_q   <= StLow;
                        end
                    end
                    StLow: begin
                        if (cnt_q == 8'd0) begin
                            sck_q   <= 1'b1;
                            rx_q    <= {rx_q[6:0], spi_so};
                            cnt_q   <= DivReload;
                            state_q <= StHigh;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    StHigh: begin
                        if (cnt_q == 8'd0) begin
                            sck_q <= 1'b0;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= StIdle;
                            end else begin
                                tx_q      <= {tx_q[6:0], 1'b0};
                                si_q      <= tx_q[6];
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                cnt_q     <= DivReload;
                                state_q   <= StLow;
                            end
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Directed bench for spi_flash_ctrl: one instance at CLK_DIV=2 (SO looped to SI) and one at
// CLK_DIV=1 (SO tied low), sharing the CPU bus; expectations flow through a FIFO scoreboard.
module tb_spi_flash_ctrl;

    localparam logic [15:0] AData = 16'h0040;
    localparam logic [15:0] ACtrl = 16'h0041;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        io_wr = 1'b0;
    logic        io_rd = 1'b0;
    logic [15:0] mem_addr = 16'h0000;
    logic [15:0] dout = 16'h0000;
    logic        pio_sck = 1'b0;
    logic        pio_si = 1'b0;
    logic        pio_ssb = 1'b1;

    logic [15:0] io_din_a, io_din_b;
    logic        spi_clk_a, spi_si_a, spi_ssb_a, spi_so_a, busy_a;
    logic        spi_clk_b, spi_si_b, spi_ssb_b, busy_b;
    logic        spi_so_b = 1'b0;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];

    assign spi_so_a = spi_si_a;

    always #5 clk = ~clk;

    spi_flash_ctrl #(.CLK_DIV(2), .ADDR_DATA(16'h0040), .ADDR_CTRL(16'h0041)) dut_a (
        .clk(clk), .reset(reset), .io_wr(io_wr), .io_rd(io_rd), .mem_addr(mem_addr),
        .dout(dout), .io_din(io_din_a), .pio_sck(pio_sck), .pio_si(pio_si),
        .pio_ssb(pio_ssb), .spi_clk(spi_clk_a), .spi_si(spi_si_a), .spi_ssb(spi_ssb_a),
        .spi_so(spi_so_a), .busy(busy_a)
    );

    spi_flash_ctrl #(.CLK_DIV(1), .ADDR_DATA(16'h0040), .ADDR_CTRL(16'h0041)) dut_b (
        .clk(clk), .reset(reset), .io_wr(io_wr), .io_rd(io_rd), .mem_addr(mem_addr),
        .dout(dout), .io_din(io_din_b), .pio_sck(pio_sck), .pio_si(pio_si),
        .pio_ssb(pio_ssb), .spi_clk(spi_clk_b), .spi_si(spi_si_b), .spi_ssb(spi_ssb_b),
        .spi_so(spi_so_b), .busy(busy_b)
    );

    task automatic push(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [15:0] obs);
        logic [15:0] exp;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: observed=%h but scoreboard empty", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            end
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic io_write(input logic [15:0] addr, input logic [15:0] data);
        io_wr = 1'b1;
        mem_addr = addr;
        dout = data;
        @(negedge clk);
        io_wr = 1'b0;
        mem_addr = 16'h0000;
        dout = 16'h0000;
    endtask

    task automatic read_a(input logic [15:0] addr, output logic [15:0] data);
        mem_addr = addr;
        #1;
        data = io_din_a;
    endtask

    task automatic wait_rises_a(input int n);
        int seen;
        logic prev;
        seen = 0;
        prev = spi_clk_a;
        for (int i = 0; i < 300 && seen < n; i++) begin
            @(negedge clk);
            if (spi_clk_a && !prev) seen++;
            prev = spi_clk_a;
        end
        push(16'(n));
        check("sck_rises_reached", 16'(seen));
    endtask

    task automatic wait_idle_a;
        for (int i = 0; i < 300 && busy_a; i++) @(negedge clk);
        push(16'd0);
        check("idle_reached", 16'(busy_a));
    endtask

    task automatic run_xfer_a(input bit chk_si, output int nbusy, output int npulse,
                              output int nssb);
        logic prev;
        nbusy = 0;
        npulse = 0;
        nssb = 0;
        prev = spi_clk_a;
        for (int i = 0; i < 300 && busy_a; i++) begin
            nbusy++;
            if (spi_clk_a && !prev) begin
                npulse++;
                if (chk_si) check("si_bit", 16'(spi_si_a));
            end
            if (spi_ssb_a) nssb++;
            prev = spi_clk_a;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] rd;
        int nbusy, npulse, nssb;
        logic [7:0] tx_byte;
        int t, last_rise, gap_min, gap_max;
        logic prev;

        // Reset and reset-state checks.
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        read_a(ACtrl, rd);
        push(16'h0000); check("reset_ctrl", rd);
        read_a(AData, rd);
        push(16'h0000); check("reset_data", rd);
        read_a(16'h0042, rd);
        push(16'h0000); check("other_addr", rd);
        push(16'h0000); check("reset_busy", 16'(busy_a));

        // Byte transfer A5 with loopback.
        io_write(ACtrl, 16'h0003);
        read_a(ACtrl, rd);
        push(16'h0003); check("ctrl_own_cs", rd);
        tx_byte = 8'hA5;
        for (int b = 7; b >= 0; b--) push(16'(tx_byte[b]));
        io_write(AData, 16'h00A5);
        run_xfer_a(1'b1, nbusy, npulse, nssb);
        push(16'd32); check("a5_busy_cycles", 16'(nbusy));
        push(16'd8);  check("a5_sck_pulses", 16'(npulse));
        push(16'd0);  check("a5_ssb_high_cycles", 16'(nssb));
        read_a(AData, rd);
        push(16'h00A5); check("a5_rx", rd);

        // Pass-through with own=0.
        io_write(ACtrl, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            {pio_sck, pio_si, pio_ssb} = 3'(i);
            #1;
            push(16'(i));
            check("passthru_pins", 16'({spi_clk_a, spi_si_a, spi_ssb_a}));
            @(negedge clk);
        end
        io_write(AData, 16'h0055);
        push(16'h0000); check("passthru_busy", 16'(busy_a));
        read_a(ACtrl, rd);
        push(16'h0000); check("passthru_ctrl", rd);
        {pio_sck, pio_si, pio_ssb} = 3'b001;

        // Overrun.
        io_write(ACtrl, 16'h0003);
        io_write(AData, 16'h0012);
        @(negedge clk);
        @(negedge clk);
        io_write(AData, 16'h0034);
        read_a(ACtrl, rd);
        push(16'h000F); check("ovr_ctrl", rd);
        wait_idle_a();
        read_a(AData, rd);
        push(16'h0012); check("ovr_rx_first_kept", rd);
        io_write(ACtrl, 16'h8003);
        read_a(ACtrl, rd);
        push(16'h0003); check("ovr_cleared", rd);

        // Abort during bit 3.
        {pio_sck, pio_si, pio_ssb} = 3'b101;
        io_write(AData, 16'h003C);
        wait_rises_a(4);
        io_write(ACtrl, 16'h0000);
        push(16'h0000); check("abort_busy", 16'(busy_a));
        push(16'h0000); check("abort_sck", 16'(dut_a.sck_q));
        push(16'h0005); check("abort_pins_pio", 16'({spi_clk_a, spi_si_a, spi_ssb_a}));
        read_a(AData, rd);
        push(16'h0023); check("abort_rx_partial", rd);
        io_write(ACtrl, 16'h0001);
        push(16'h0001); check("own_nocs_clk_ssb", 16'({spi_clk_a, spi_ssb_a}));
        io_write(ACtrl, 16'h0003);
        io_write(AData, 16'h0096);
        run_xfer_a(1'b0, nbusy, npulse, nssb);
        push(16'd32); check("post_abort_busy", 16'(nbusy));
        push(16'd8);  check("post_abort_pulses", 16'(npulse));
        read_a(AData, rd);
        push(16'h0096); check("post_abort_rx", rd);

        // Reset at bit 5, with a concurrent ctrl write that must lose.
        {pio_sck, pio_si, pio_ssb} = 3'b010;
        io_write(AData, 16'h00C3);
        wait_rises_a(6);
        reset = 1'b1;
        io_write(ACtrl, 16'h0003);
        reset = 1'b0;
        push(16'h0000); check("rst_busy", 16'(busy_a));
        push(16'h0002); check("rst_pins_pio", 16'({spi_clk_a, spi_si_a, spi_ssb_a}));
        read_a(ACtrl, rd);
        push(16'h0000); check("rst_ctrl", rd);
        read_a(AData, rd);
        push(16'h0000); check("rst_rx", rd);
        push(16'h0000);
        check("rst_regs", {dut_a.tx_q, dut_a.cnt_q});
        push(16'h0000);
        check("rst_bits", 16'({dut_a.sck_q, dut_a.si_q, dut_a.bit_cnt_q}));
        nssb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dut_a.sck_q || spi_clk_a) nssb++;
        end
        push(16'd0); check("rst_no_pending_sck", 16'(nssb));

        // Minimum divider on the CLK_DIV=1 instance, FF out, SO tied low.
        {pio_sck, pio_si, pio_ssb} = 3'b001;
        io_write(ACtrl, 16'h0003);
        io_write(AData, 16'h00FF);
        t = 0;
        npulse = 0;
        last_rise = -1;
        gap_min = 99;
        gap_max = 0;
        prev = spi_clk_b;
        for (int i = 0; i < 300 && busy_b; i++) begin
            t++;
            if (spi_clk_b && !prev) begin
                npulse++;
                if (last_rise >= 0) begin
                    if (t - last_rise < gap_min) gap_min = t - last_rise;
                    if (t - last_rise > gap_max) gap_max = t - last_rise;
                end
                last_rise = t;
            end
            prev = spi_clk_b;
            @(negedge clk);
        end
        push(16'd16); check("div1_busy_cycles", 16'(t));
        push(16'd8);  check("div1_pulses", 16'(npulse));
        push(16'd2);  check("div1_period_min", 16'(gap_min));
        push(16'd2);  check("div1_period_max", 16'(gap_max));
        mem_addr = AData;
        #1;
        push(16'h0000); check("div1_rx", io_din_b);
        mem_addr = 16'h0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
